m_7seg_scan_driver: RTL and testbench
=====================================

Name: m_7seg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a multi-digit common-anode seven-segment display on the clock design.
- Captures a packed BCD/hex value into a shadow register on a load strobe.
- Scans one digit per scan period, with optional leading-zero blanking and per-digit blink.
- Successor to the single-digit combinational decoder: adds digit count, hex mode, scanning and blinking.

Parameters:
- DIGITS, 4, number of digits driven (1..8).
- SCAN_DIV, 50000, clocks per digit slot (>=1).
- BLINK_DIV, 25000000, clocks per blink half-period (>=1).
- HEX_MODE, 0, 0: codes 10-15 blank; 1: codes 10-15 show A,b,C,d,E,F.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1: display driven; 0: all digits dark.
- load  input  1  1: capture value/dp_in into shadow on this edge.
- value  input  4*DIGITS  packed digit codes; digit i = value[4i+3:4i]; digit 0 is least significant.
- dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
- lz_blank  input  1  1: blank leading zeros.
- blink_mask  input  DIGITS  1 = digit blinks.
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
- an  output  DIGITS  active-low one-hot digit select.

Behaviour:
- Reset (async, dominant over load/enable): seg=8'hFF, an=all 1, shadow value=0, shadow dp=0, scan counter=0, digit index=0, blink counter=0, blink_phase=0.
- Shadow: on load=1, value and dp_in are copied. The display uses only shadow contents. Mid-scan load takes effect from the next output register update, with no tearing within a slot.
- Scan counter runs 0..SCAN_DIV-1, free-running regardless of enable. At terminal count it wraps to 0 and the digit index advances: DIGITS-1 wraps to 0. SCAN_DIV=1 advances every clock.
- Blink counter runs 0..BLINK_DIV-1, free-running. At terminal count it wraps and blink_phase toggles.
- Segment code for {g..a} (bit7 = dp, separate):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98 (hex, bit7 shown as 1).
  - HEX_MODE=1: A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - HEX_MODE=0: codes 10-15 give FF.
- dp: seg[7]=0 when shadow dp for the digit is 1, else 1.
- Leading-zero blank: digit i (i>=1) is blank when lz_blank=1 and all shadow digits i..DIGITS-1 equal 0. Digit 0 is never lz-blanked. A blanked digit's dp still follows shadow dp.
- Blink: when blink_phase=1 and blink_mask[i]=1, digit i is fully blank (seg=FF including dp). The an bit is still asserted.
- Output register: each clock, seg/an <= f(current index, shadow, masks, blink_phase).
  - Latency: outputs reflect an index change, load or input change one clock later.
  - an = ~(1<<index) when enable=1. When enable=0: an=all 1 and seg=FF.
- Combinational inputs lz_blank, blink_mask and enable are used live, not shadowed.
- Counter widths are $clog2 of the divisor, minimum 1 bit.

Test Plan:
- Reset/idle (DIGITS=4, SCAN_DIV=4): assert rst mid-scan -> seg=FF, an=F immediately. After release and enable=1, an sequence is E,D,B,7,E… with each value held 4 clocks.
- Decode (HEX_MODE=0): load value=16'h9870, dp_in=4'b0100, lz_blank=0 -> slots 0..3 give seg C0, F8, 00 (8 with dp), 98.
- Hex mode (HEX_MODE=1): load 16'hFA3C -> seg C6, B0, 88, 8E. Rebuild with HEX_MODE=0 -> C6 becomes FF, 88 becomes FF, 8E becomes FF.
- Leading-zero: load 16'h0005 with lz_blank=1 -> digits 3..1 give FF and digit 0 gives 92. Load 16'h0000 -> digit 0 gives C0, others FF.
- Blink (BLINK_DIV=8): blink_mask=4'b0001 -> digit 0 toggles between its code and FF every 8 clocks. Other digits are unaffected and an keeps scanning.
- Load/enable interaction: change value without load -> no display change. Pulse load mid-slot -> new code appears 1 clock after the load edge. enable=0 -> seg=FF, an=F one clock later, and the scan position is preserved on re-enable.

Source files
------------

// File: rtl/m_7seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed digit codes,
// one digit lit per scan slot, leading-zero blanking and per-digit blink.
module m_7seg_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int HEX_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [DIGITS-1:0]   lz_hit;
  logic                all_zero;
  logic [3:0]          cur_code;

  // Active-low {g..a}; codes 10-15 only render when HEX_MODE is set.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      4'd10:   s = (HEX_MODE != 0) ? 7'h08 : 7'h7F;
      4'd11:   s = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
      4'd12:   s = (HEX_MODE != 0) ? 7'h46 : 7'h7F;
      4'd13:   s = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
      4'd14:   s = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
      default: s = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    value_d       = load ? value : value_q;
    dp_d          = load ? dp_in : dp_q;
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // A digit is a leading zero when it and every more-significant digit is 0.
    all_zero = 1'b1;
    lz_hit   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero  = all_zero & (value_q[4*i +: 4] == 4'd0);
      lz_hit[i] = lz_blank & all_zero & (i != 0);
    end

    cur_code = value_q[{idx_q, 2'b00} +: 4];
    seg_d    = 8'hFF;
    an_d     = '1;
    if (enable) begin
      an_d = ~(DIGITS'(1) << idx_q);
      if (!(blink_phase_q && blink_mask[idx_q])) begin
        seg_d[7]   = ~dp_q[idx_q];
        seg_d[6:0] = lz_hit[idx_q] ? 7'h7F : decode(cur_code);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q       <= '0;
      dp_q          <= '0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= 8'hFF;
      an_q          <= '1;
    end else begin
      value_q       <= value_d;
      dp_q          <= dp_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_m_7seg_scan_driver.sv
// Bench for m_7seg_scan_driver: a decimal-mode and a hex-mode instance share
// stimulus; directed expectations are queued and checked by a separate monitor.
module tb_m_7seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [7:0]  seg_dec, seg_hex;
  logic [3:0]  an_dec, an_hex;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // Entry layout: {hex_instance, seg[7:0], an[3:0]}
  logic [12:0] exp_q[$];
  string       name_q[$];

  m_7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8), .HEX_MODE(0)) u_dec (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .blink_mask(blink_mask),
    .seg(seg_dec), .an(an_dec)
  );

  m_7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .blink_mask(blink_mask),
    .seg(seg_hex), .an(an_hex)
  );

  // Clock / reset-relative cycle count: cyc = rising edges since reset released.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Monitor: outputs are registered, so every negedge+1 is a valid sample point.
  always @(negedge clk) begin
    logic [12:0] e;
    string       nm;
    logic [7:0]  gs;
    logic [3:0]  ga;
    #1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      gs = e[12] ? seg_hex : seg_dec;
      ga = e[12] ? an_hex : an_dec;
      total++;
      if (gs !== e[11:4] || ga !== e[3:0]) begin
        bad++;
        $display("FAIL %s hex=%0d cyc=%0d seg got %h want %h, an got %h want %h",
                 nm, e[12], cyc, gs, e[11:4], ga, e[3:0]);
      end
    end
  end

  // Driver tasks
  task automatic at(input int n);
    if (cyc > n) begin
      total++;
      bad++;
      $display("FAIL schedule: cyc got %0d want <= %0d", cyc, n);
    end
    while (cyc < n) @(negedge clk);
  endtask

  task automatic expect_now(input string nm, input logic [7:0] sd,
                            input logic [7:0] sh, input logic [3:0] a);
    exp_q.push_back({1'b0, sd, a});
    name_q.push_back(nm);
    exp_q.push_back({1'b1, sh, a});
    name_q.push_back(nm);
  endtask

  task automatic chk(input int n, input string nm, input logic [7:0] sd,
                     input logic [7:0] sh, input logic [3:0] a);
    at(n);
    expect_now(nm, sd, sh, a);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    expect_now("reset", 8'hFF, 8'hFF, 4'hF);

    // Scan order with all-zero shadow: each an value held four clocks
    rst    = 1'b0;
    enable = 1'b1;
    chk(1,  "scan0",  8'hC0, 8'hC0, 4'hE);
    chk(4,  "scan0e", 8'hC0, 8'hC0, 4'hE);
    chk(5,  "scan1",  8'hC0, 8'hC0, 4'hD);
    chk(9,  "scan2",  8'hC0, 8'hC0, 4'hB);
    chk(13, "scan3",  8'hC0, 8'hC0, 4'h7);
    chk(17, "wrap",   8'hC0, 8'hC0, 4'hE);

    // Asynchronous reset mid-slot
    at(18);
    rst = 1'b1;
    expect_now("async_rst", 8'hFF, 8'hFF, 4'hF);
    @(negedge clk);
    rst = 1'b0;

    // Decimal decode with one decimal point
    do_load(16'h9870, 4'b0100);
    chk(2,  "dec_d0", 8'hC0, 8'hC0, 4'hE);
    chk(5,  "dec_d1", 8'hF8, 8'hF8, 4'hD);
    chk(9,  "dec_dp", 8'h00, 8'h00, 4'hB);
    chk(13, "dec_d3", 8'h98, 8'h98, 4'h7);

    // Codes 10-15: letters only on the hex instance
    at(16);
    do_load(16'hFA3C, 4'b0000);
    chk(18, "hex_C", 8'hFF, 8'hC6, 4'hE);
    chk(21, "hex_3", 8'hB0, 8'hB0, 4'hD);
    chk(25, "hex_A", 8'hFF, 8'h88, 4'hB);
    chk(29, "hex_F", 8'hFF, 8'h8E, 4'h7);

    // Leading-zero blanking
    at(30);
    lz_blank = 1'b1;
    do_load(16'h0005, 4'b0000);
    chk(32, "lz_d3", 8'hFF, 8'hFF, 4'h7);
    chk(33, "lz_d0", 8'h92, 8'h92, 4'hE);
    chk(37, "lz_d1", 8'hFF, 8'hFF, 4'hD);
    chk(41, "lz_d2", 8'hFF, 8'hFF, 4'hB);
    do_load(16'h0000, 4'b0010);
    chk(45, "lz0_d3", 8'hFF, 8'hFF, 4'h7);
    chk(49, "lz0_d0", 8'hC0, 8'hC0, 4'hE);
    chk(53, "lz_dp",  8'h7F, 8'h7F, 4'hD);

    // Blink: digits 0,1 always fall in phase 0, digits 2,3 in phase 1
    at(54);
    lz_blank   = 1'b0;
    blink_mask = 4'b0101;
    do_load(16'h4321, 4'b1000);
    chk(65, "blk_d0_on",  8'hF9, 8'hF9, 4'hE);
    chk(69, "blk_d1",     8'hA4, 8'hA4, 4'hD);
    chk(73, "blk_d2_off", 8'hFF, 8'hFF, 4'hB);
    chk(77, "blk_d3_dp",  8'h19, 8'h19, 4'h7);
    blink_mask = 4'b1000;
    chk(81, "blk_d0",     8'hF9, 8'hF9, 4'hE);
    chk(89, "blk_d2_on",  8'hB0, 8'hB0, 4'hB);
    chk(93, "blk_d3_off", 8'hFF, 8'hFF, 4'h7);

    // Shadow isolation, mid-slot load, enable gating
    blink_mask = 4'b0000;
    dp_in      = 4'b0000;
    value      = 16'h5555;
    chk(97, "no_load", 8'hF9, 8'hF9, 4'hE);
    at(98);
    do_load(16'h5555, 4'b0000);
    expect_now("load_edge", 8'hF9, 8'hF9, 4'hE);
    chk(100, "load_next", 8'h92, 8'h92, 4'hE);
    chk(101, "pre_dis",   8'h92, 8'h92, 4'hD);
    enable = 1'b0;
    chk(102, "dis",       8'hFF, 8'hFF, 4'hF);
    chk(110, "dis_hold",  8'hFF, 8'hFF, 4'hF);
    enable = 1'b1;
    chk(111, "reen_pos",  8'h92, 8'h92, 4'h7);
    chk(113, "reen_wrap", 8'h92, 8'h92, 4'hE);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: queue got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
